// File: rtl/rvtu_mem_arb_pkg.sv
// Shared types and helpers for the RVTU memory arbiter: FSM state, transaction owner and the
// registered bus command.
package rvtu_mem_arb_pkg;

  localparam int unsigned XLen = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} memArbState_t;
  typedef enum logic {OWN_F, OWN_D} memArbOwner_t;

  typedef struct packed {
    logic            we;
    logic [3:0]      wmask;
    logic [XLen-1:0] addr;
    logic [XLen-1:0] wdata;
  } mem_arb_cmd_t;

  // Fetches are always word-aligned full-word reads.
  function automatic mem_arb_cmd_t fetch_cmd(input logic [XLen-1:0] addr);
    mem_arb_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.wmask = 4'hF;
    cmd.addr  = addr & ~32'h3;
    cmd.wdata = '0;
    return cmd;
  endfunction

endpackage

// File: rtl/rvtu_mem_arb_if.sv
// External memory bus: one command/grant handshake and a response-valid/data return path.
interface rvtu_mem_arb_if;
  import rvtu_mem_arb_pkg::*;

  logic            b_req;
  logic            b_we;
  logic [3:0]      b_wmask;
  logic [XLen-1:0] b_addr;
  logic [XLen-1:0] b_wdata;
  logic            b_gnt;
  logic            b_rvalid;
  logic [XLen-1:0] b_rdata;

  modport master (
    output b_req, b_we, b_wmask, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  b_req, b_we, b_wmask, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata
  );

endinterface

// File: rtl/rvtu_mem_arb.sv
// Arbitrates the always-requesting fetch port and the data port onto one bus with a single
// outstanding transaction; responses return as one-cycle pulses to the owning port.
module rvtu_mem_arb
  import rvtu_mem_arb_pkg::*;
#(
  parameter bit rr_en = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLen-1:0] f_addr,
  output logic [XLen-1:0] f_rdata,
  output logic            f_resp,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_wmask,
  input  logic [XLen-1:0] d_addr,
  input  logic [XLen-1:0] d_wdata,
  output logic [XLen-1:0] d_rdata,
  output logic            d_resp,
  rvtu_mem_arb_if.master  bus
);

  memArbState_t state_q, state_d;
  memArbOwner_t owner_q, owner_d;
  memArbOwner_t last_q, last_d;
  mem_arb_cmd_t cmd_q, cmd_d;
  logic         b_req_q, b_req_d;

  logic grant, pick_d, rsp;

  // A response cycle doubles as the next grant point, giving one transaction per 2 cycles.
  assign rsp    = (state_q == WAIT) && bus.b_rvalid;
  assign grant  = (state_q == IDLE) || rsp;
  assign pick_d = rr_en ? (d_req && (last_q == OWN_F)) : d_req;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    b_req_d = b_req_q;
    unique case (state_q)
      IDLE, WAIT: begin
        if (grant) begin
          owner_d = pick_d ? OWN_D : OWN_F;
          last_d  = owner_d;
          cmd_d   = pick_d ? '{we: d_we, wmask: d_wmask, addr: d_addr, wdata: d_wdata}
                           : fetch_cmd(f_addr);
          state_d = REQ;
          b_req_d = 1'b1;
        end
      end
      REQ: begin
        if (bus.b_gnt) begin
          state_d = WAIT;
          b_req_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        b_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_F;
      last_q  <= OWN_D;
      cmd_q   <= '0;
      b_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      b_req_q <= b_req_d;
    end
  end

  assign bus.b_req   = b_req_q;
  assign bus.b_we    = cmd_q.we;
  assign bus.b_wmask = cmd_q.wmask;
  assign bus.b_addr  = cmd_q.addr;
  assign bus.b_wdata = cmd_q.wdata;

  assign f_resp  = rsp && (owner_q == OWN_F);
  assign d_resp  = rsp && (owner_q == OWN_D);
  assign f_rdata = bus.b_rdata;
  assign d_rdata = bus.b_rdata;

endmodule

// File: tb/tb_rvtu_mem_arb.sv
// Directed bench: round-robin arbiter (dut0) with a scriptable bus, plus a data-priority
// arbiter (dut1) whose data port requests continuously.
module tb_rvtu_mem_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // dut0 stimulus
  logic [31:0] f_addr = 32'h4000_0006;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_wmask = 4'hF;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] f_rdata, d_rdata;
  logic        f_resp, d_resp;

  // dut1 stimulus: data always requesting a load from 0x2000
  logic [31:0] f_rdata1, d_rdata1;
  logic        f_resp1, d_resp1;

  // bus models
  logic        gnt_en = 1'b1, rv_hold = 1'b0, rv_force = 1'b0;
  logic        rv0_q, rv1_q;
  logic [31:0] rdata_v = 32'hCAFE_0001;

  rvtu_mem_arb_if bus0 ();
  rvtu_mem_arb_if bus1 ();

  assign bus0.b_gnt    = gnt_en;
  assign bus0.b_rvalid = (rv0_q & ~rv_hold) | rv_force;
  assign bus0.b_rdata  = rdata_v;
  assign bus1.b_gnt    = 1'b1;
  assign bus1.b_rvalid = rv1_q;
  assign bus1.b_rdata  = 32'h0BAD_F00D;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= bus0.b_req & bus0.b_gnt;
      rv1_q <= bus1.b_req & bus1.b_gnt;
    end
  end

  rvtu_mem_arb #(.rr_en(1'b1)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_addr  (f_addr),
    .f_rdata (f_rdata),
    .f_resp  (f_resp),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_wmask (d_wmask),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_resp  (d_resp),
    .bus     (bus0)
  );

  rvtu_mem_arb #(.rr_en(1'b0)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_addr  (f_addr),
    .f_rdata (f_rdata1),
    .f_resp  (f_resp1),
    .d_req   (1'b1),
    .d_we    (1'b0),
    .d_wmask (4'hF),
    .d_addr  (32'h0000_2000),
    .d_wdata (32'h0),
    .d_rdata (d_rdata1),
    .d_resp  (d_resp1),
    .bus     (bus1)
  );

  // Response counters and owner log, sampled mid-low-phase after stimulus has settled.
  int f_cnt = 0, d_cnt = 0, f_cnt1 = 0, d_cnt1 = 0;
  logic log_q[$];
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (f_resp) begin f_cnt++; log_q.push_back(1'b0); end
      if (d_resp) begin d_cnt++; log_q.push_back(1'b1); end
      if (f_resp1) f_cnt1++;
      if (d_resp1) d_cnt1++;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) (d_req && !d_resp) |=> d_req)
    else $error("FAIL d_req_hold: d_req dropped before d_resp");

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required $finish earlier");
    $fatal(1);
  end

  task automatic test_reset;
    @(negedge clk); #1;
    total++; if (bus0.b_req !== 1'b0) $display("FAIL rst_b_req got %b exp 0", bus0.b_req); else passed++;
    total++; if (f_resp !== 1'b0) $display("FAIL rst_f_resp got %b exp 0", f_resp); else passed++;
    total++; if (d_resp !== 1'b0) $display("FAIL rst_d_resp got %b exp 0", d_resp); else passed++;
    total++; if (bus0.b_addr !== 32'h0) $display("FAIL rst_b_addr got %h exp 0", bus0.b_addr); else passed++;
    total++; if (bus0.b_wmask !== 4'h0) $display("FAIL rst_b_wmask got %h exp 0", bus0.b_wmask); else passed++;
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (bus0.b_req !== 1'b0) $display("FAIL c0_b_req got %b exp 0", bus0.b_req); else passed++;
    @(negedge clk); #1;
    total++; if (bus0.b_req !== 1'b1) $display("FAIL c1_b_req got %b exp 1", bus0.b_req); else passed++;
    total++; if (bus0.b_addr !== 32'h4000_0004) $display("FAIL c1_b_addr got %h exp 40000004", bus0.b_addr); else passed++;
    total++; if (bus0.b_we !== 1'b0) $display("FAIL c1_b_we got %b exp 0", bus0.b_we); else passed++;
    total++; if (bus0.b_wmask !== 4'hF) $display("FAIL c1_b_wmask got %h exp f", bus0.b_wmask); else passed++;
    total++; if (f_resp !== 1'b0) $display("FAIL c1_f_resp got %b exp 0", f_resp); else passed++;
    @(negedge clk); f_addr = 32'h4000_000A; #1;
    total++; if (f_resp !== 1'b1) $display("FAIL c2_f_resp got %b exp 1", f_resp); else passed++;
    total++; if (d_resp !== 1'b0) $display("FAIL c2_d_resp got %b exp 0", d_resp); else passed++;
    total++; if (f_rdata !== 32'hCAFE_0001) $display("FAIL c2_f_rdata got %h exp cafe0001", f_rdata); else passed++;
    @(negedge clk); #1;
    total++; if (bus0.b_req !== 1'b1) $display("FAIL c3_b_req got %b exp 1", bus0.b_req); else passed++;
    total++; if (bus0.b_addr !== 32'h4000_0008) $display("FAIL c3_b_addr got %h exp 40000008", bus0.b_addr); else passed++;
  endtask

  task automatic test_round_robin;
    int f0, d0;
    d_req = 1'b1; d_we = 1'b0; d_wmask = 4'hF; d_addr = 32'h3000; d_wdata = '0;
    log_q.delete();
    f0 = f_cnt; d0 = d_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (log_q.size() >= 4) break;
    end
    d_req = 1'b0;
    total++; if (log_q.size() < 4) $display("FAIL rr_timeout got %0d responses exp 4", log_q.size()); else passed++;
    if (log_q.size() >= 4) begin
      total++;
      if ({log_q[0], log_q[1], log_q[2], log_q[3]} !== 4'b0101)
        $display("FAIL rr_order got %b%b%b%b exp 0101 (F=0 D=1)", log_q[0], log_q[1], log_q[2], log_q[3]);
      else passed++;
    end
    total++; if (f_cnt - f0 != 2) $display("FAIL rr_f_cnt got %0d exp 2", f_cnt - f0); else passed++;
    total++; if (d_cnt - d0 != 2) $display("FAIL rr_d_cnt got %0d exp 2", d_cnt - d0); else passed++;
  endtask

  task automatic test_store;
    int d0;
    logic seen, resp_seen;
    logic [31:0] got;
    seen = 1'b0; resp_seen = 1'b0; got = '0;
    rdata_v = 32'h5555_AAAA;
    d_req = 1'b1; d_we = 1'b1; d_wmask = 4'b0010; d_addr = 32'h1003; d_wdata = 32'hAB00;
    d0 = d_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus0.b_req && bus0.b_we) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL st_issue got no store on bus exp one"); else passed++;
    total++; if (bus0.b_addr !== 32'h1003) $display("FAIL st_b_addr got %h exp 1003", bus0.b_addr); else passed++;
    total++; if (bus0.b_wmask !== 4'b0010) $display("FAIL st_b_wmask got %b exp 0010", bus0.b_wmask); else passed++;
    total++; if (bus0.b_wdata !== 32'hAB00) $display("FAIL st_b_wdata got %h exp ab00", bus0.b_wdata); else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (d_resp) begin resp_seen = 1'b1; got = d_rdata; break; end
    end
    total++; if (!resp_seen) $display("FAIL st_resp got none exp d_resp pulse"); else passed++;
    total++; if (got !== 32'h5555_AAAA) $display("FAIL st_d_rdata got %h exp 5555aaaa", got); else passed++;
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    total++; if (d_cnt - d0 != 1) $display("FAIL st_d_cnt got %0d exp 1", d_cnt - d0); else passed++;
  endtask

  task automatic test_gnt_withheld;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (f_resp) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL gw_sync got no f_resp exp one"); else passed++;
    f_addr = 32'h4000_0100;
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      f_addr = 32'h5000_0000 + 32'(i * 16);
      #1;
      total++; if (bus0.b_req !== 1'b1) $display("FAIL gw_b_req[%0d] got %b exp 1", i, bus0.b_req); else passed++;
      total++; if (bus0.b_addr !== 32'h4000_0100) $display("FAIL gw_b_addr[%0d] got %h exp 40000100", i, bus0.b_addr); else passed++;
    end
    gnt_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (f_resp) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL gw_resp got no f_resp exp one after grant"); else passed++;
  endtask

  task automatic test_reset_mid;
    int f0, d0;
    logic seen;
    seen = 1'b0;
    f_addr = 32'h4000_0200;
    @(negedge clk);
    rv_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      if (bus0.b_req) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL rm_sync got no b_req exp one"); else passed++;
    @(negedge clk); #1;
    total++; if (f_resp !== 1'b0) $display("FAIL rm_wait_f_resp got %b exp 0", f_resp); else passed++;
    f0 = f_cnt; d0 = d_cnt;
    rst_n = 1'b0; #1;
    total++; if (bus0.b_req !== 1'b0) $display("FAIL rm_rst_b_req got %b exp 0", bus0.b_req); else passed++;
    total++; if (bus0.b_addr !== 32'h0) $display("FAIL rm_rst_b_addr got %h exp 0", bus0.b_addr); else passed++;
    @(negedge clk);
    rst_n = 1'b1; rv_hold = 1'b0; rv_force = 1'b1; #1;
    total++; if (f_resp !== 1'b0) $display("FAIL rm_idle_f_resp got %b exp 0", f_resp); else passed++;
    total++; if (d_resp !== 1'b0) $display("FAIL rm_idle_d_resp got %b exp 0", d_resp); else passed++;
    total++; if (bus0.b_req !== 1'b0) $display("FAIL rm_idle_b_req got %b exp 0", bus0.b_req); else passed++;
    @(negedge clk);
    rv_force = 1'b0; #1;
    total++; if (bus0.b_req !== 1'b1) $display("FAIL rm_req_b_req got %b exp 1", bus0.b_req); else passed++;
    total++; if (bus0.b_addr !== 32'h4000_0200) $display("FAIL rm_req_b_addr got %h exp 40000200", bus0.b_addr); else passed++;
    total++; if (f_cnt != f0 || d_cnt != d0) $display("FAIL rm_no_pulse got f+%0d d+%0d exp 0 0", f_cnt - f0, d_cnt - d0); else passed++;
  endtask

  task automatic test_fixed_priority;
    int d1;
    logic seen;
    seen = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (bus1.b_req) begin seen = 1'b1; break; end
    end
    total++; if (!seen) $display("FAIL fp_sync got no b_req exp one"); else passed++;
    total++; if (bus1.b_addr !== 32'h2000) $display("FAIL fp_b_addr got %h exp 2000", bus1.b_addr); else passed++;
    d1 = d_cnt1;
    repeat (20) @(negedge clk);
    #1;
    total++; if (d_cnt1 - d1 != 10) $display("FAIL fp_d_cnt got %0d exp 10", d_cnt1 - d1); else passed++;
    total++; if (f_cnt1 != 0) $display("FAIL fp_f_cnt got %0d exp 0", f_cnt1); else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_store();
    test_gnt_withheld();
    test_reset_mid();
    test_fixed_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rvtu_mem_arb.md
# rvtu_mem_arb

Memory arbiter and responder sitting between the RVTU front end's fetch port, the RVTU data (load/store) port, and a single external memory bus. It accepts the front end's combinational fetch address, services it or a pending data request on the bus with one transaction outstanding, and returns each response as a single-cycle `mresp`-style pulse to the port that owns the transaction. Arbitration between fetch and data is round-robin by default, so neither port starves.

## Interface
Parameters:
- `rr_en`, default 1: 1 = round-robin between fetch and data; 0 = data always wins when `d_req` is high.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `f_addr`  in  32  fetch address (front-end `maddr`), sampled only at grant points
- `f_rdata`  out  32  fetch data, equal to `b_rdata`
- `f_resp`  out  1  fetch response pulse
- `d_req`  in  1  data request, level; held with its fields stable until `d_resp`
- `d_we`  in  1  1 = store
- `d_wmask`  in  4  store byte enables
- `d_addr`  in  32  data address
- `d_wdata`  in  32  store data
- `d_rdata`  out  32  load data, equal to `b_rdata`
- `d_resp`  out  1  data response pulse, for loads and stores
- `b_req`  out  1  bus request, held until `b_gnt`
- `b_we`, `b_wmask`, `b_addr`, `b_wdata`  out  1/4/32/32  bus command, driven from the internal command register
- `b_gnt`  in  1  bus accepts the command this cycle when `b_req & b_gnt`
- `b_rvalid`  in  1  bus response valid
- `b_rdata`  in  32  bus response data

## Operation
- The fetch port always requests. The front end issues no request strobe.
- States:
  - IDLE: the one cycle after reset release.
  - REQ: `b_req` high, waiting for `b_gnt`.
  - WAIT: waiting for `b_rvalid`.
- A grant point is IDLE, or WAIT with `b_rvalid`=1. At a grant point:
  - Choose the owner. If `rr_en`=1: data if `d_req` is high and the last owner was fetch; otherwise fetch. If `rr_en`=0: data if `d_req` is high.
  - Latch owner and command. Fetch command is `b_we`=0, `b_wmask`=4'hF, `b_addr`={f_addr[31:2],2'b00}. Data command is `d_*` as presented, with `d_addr` unmodified.
  - Go to REQ.
- REQ goes to WAIT on `b_gnt`. WAIT stays in WAIT until `b_rvalid`.
- Response outputs:
  - `f_resp` = WAIT & `b_rvalid` & owner==fetch.
  - `d_resp` = WAIT & `b_rvalid` & owner==data.
  - `b_rvalid` outside WAIT is ignored.
- Fetch data is always returned. Front-end stall and flush are handled entirely inside the front end, which re-presents the old address or discards the data. The arbiter never cancels a transaction.
- `d_req` dropped before `d_resp` is a protocol violation; the bench asserts it.
- The command register is written only at grant points and is stable throughout REQ.

## Timing
- Reset values: state IDLE, `b_req`=0, `f_resp`=0, `d_resp`=0, owner=fetch, last owner=data (so the first grant goes to fetch), command register 0.
- Minimum latency is 2 cycles from grant point (t) to response pulse: REQ at t+1 with `b_gnt`=1, WAIT at t+2 with `b_rvalid`=1.
- Back-to-back: a response cycle is also a grant point, so `b_req` is high again the next cycle. Peak throughput is one transaction per 2 cycles.
- The fetch address is sampled in the response cycle. That is the cycle in which the front end already presents its next pc.
- `d_req` rising in the same cycle as a fetch response wins that grant point (rr_en=1 and last owner fetch).
- Reset asserted mid-transaction: the transaction is abandoned and no response pulse is emitted. The bus is reset by the same `rst_n`.
- The front end must see reset for at least one clock edge so `f_addr` is valid in IDLE.

## Structure
- Add `memArbState_t` {IDLE, REQ, WAIT} and `memArbOwner_t` {OWN_F, OWN_D} to `rv_pkg`.
- Single module, no sub-modules. The 2-way round-robin is one flop plus a small combinational pick.

## Test plan
- Reset release with `f_addr`=0x40000000, bus granting immediately and `b_rvalid` one cycle later -> `b_addr`=0x40000000 in cycle 1, `f_resp`=1 with `f_rdata`=`b_rdata` in cycle 2, next `b_req` in cycle 3.
- `d_req` held constantly with `rr_en`=1 -> owners alternate F,D,F,D. Each port gets exactly one response per two transactions.
- `rr_en`=0 with `d_req` constantly high -> every grant after the first goes to data and `f_resp` never pulses.
- Store `d_addr`=0x1003, `d_wmask`=4'b0010, `d_wdata`=0xAB00 -> bus sees these exact values with `b_we`=1, and `d_resp` pulses once.
- `b_gnt` withheld 5 cycles while `f_addr` changes -> `b_addr` stays at the latched value and `b_req` stays high all 5 cycles.
- `rst_n` dropped during WAIT, then `b_rvalid`=1 after release -> no `f_resp`/`d_resp` pulse, and the FSM restarts from IDLE.
